// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencer slice.
// Contents: the sequencer state type and the default PC width and
// return-stack depth.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam int DEF_PC_W    = 8;
    localparam int DEF_STACK_D = 4;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Control and fetch bus between the decoder/ALU and the fetch sequencer.
// Signals:
//   start, start_addr           : run/restart request and its load address
//   stall                       : hold the current PC
//   branch, taken, abs_jump     : branch request, condition, target mode
//   rel_jump                    : signed offset or absolute target
//   call, ret, halt_req         : stack and halt requests
//   pc_out, fetch_valid, halt   : fetch address and run status
//   stack_overflow/underflow    : sticky stack error flags
// Modports: master = decoder side, slave = fetch_sequencer.
interface fetch_sequencer_if #(
    parameter int PC_W = fetch_pkg::DEF_PC_W
);
    logic            start;
    logic [PC_W-1:0] start_addr;
    logic            stall;
    logic            branch;
    logic            taken;
    logic            abs_jump;
    logic [PC_W-1:0] rel_jump;
    logic            call;
    logic            ret;
    logic            halt_req;
    logic [PC_W-1:0] pc_out;
    logic            fetch_valid;
    logic            halt;
    logic            stack_overflow;
    logic            stack_underflow;

    modport master (
        output start, start_addr, stall, branch, taken, abs_jump, rel_jump,
               call, ret, halt_req,
        input  pc_out, fetch_valid, halt, stack_overflow, stack_underflow
    );

    modport slave (
        input  start, start_addr, stall, branch, taken, abs_jump, rel_jump,
               call, ret, halt_req,
        output pc_out, fetch_valid, halt, stack_overflow, stack_underflow
    );
endinterface

// File: rtl/ret_stack.sv
// Return-address LIFO, STACK_D entries of PC_W bits.
// Ports:
//   CLK, reset     : clock, asynchronous active-high reset
//   push, pop      : write din on top / drop the top entry
//   clear          : empty the stack (wins over push and pop)
//   din, dout      : push data, current top entry
//   full, empty    : occupancy flags
// No error checking: the caller must not push when full or pop when empty.
module ret_stack #(
    parameter int PC_W    = fetch_pkg::DEF_PC_W,
    parameter int STACK_D = fetch_pkg::DEF_STACK_D
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic            clear,
    input  logic [PC_W-1:0] din,
    output logic [PC_W-1:0] dout,
    output logic            full,
    output logic            empty
);
    localparam int AW   = $clog2(STACK_D);
    localparam int SP_W = AW + 1;

    logic [PC_W-1:0] mem [STACK_D];
    logic [SP_W-1:0] sp;
    logic [AW-1:0]   top_idx;

    // Wraps to the last entry when empty; dout is then meaningless but in range.
    assign top_idx = sp[AW-1:0] - AW'(1);
    assign dout    = mem[top_idx];
    assign full    = (sp == SP_W'(STACK_D));
    assign empty   = (sp == '0);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            sp <= '0;
        end else if (clear) begin
            sp <= '0;
        end else if (push) begin
            sp <= sp + SP_W'(1);
        end else if (pop) begin
            sp <= sp - SP_W'(1);
        end
    end

    // Storage is not reset; only sp defines which entries are live.
    always_ff @(posedge CLK) begin
        if (push && !clear) begin
            mem[sp[AW-1:0]] <= din;
        end
    end
endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-ROM address sequencer with run control, branches and a
// hardware call/return stack.
// Ports:
//   CLK, reset : clock, asynchronous active-high reset
//   bus        : fetch_sequencer_if slave (controls in, pc_out/status out)
//
// state | meaning
// IDLE  | out of reset, waiting for start, pc_out holds
// RUN   | fetching; pc_out advances, branches, calls or returns
// HALT  | stopped by halt_req or a stack error; only start leaves
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int PC_W    = DEF_PC_W,
    parameter int STACK_D = DEF_STACK_D
) (
    input logic               CLK,
    input logic               reset,
    fetch_sequencer_if.slave  bus
);
    fetch_state_t    state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] target;
    logic            fetch_valid_q;
    logic            halt_q;
    logic            ovf_q;
    logic            unf_q;
    logic            active;
    logic            push;
    logic            pop;
    logic [PC_W-1:0] stk_top;
    logic            stk_full;
    logic            stk_empty;

    assign pc_inc = pc + PC_W'(1);
    // Modular add: the two's-complement offset needs no sign extension.
    assign target = bus.abs_jump ? bus.rel_jump : pc + bus.rel_jump;

    // A cycle in which RUN is actually allowed to act on controls.
    assign active = (state == RUN) && !bus.stall && !bus.start && !bus.halt_req;
    assign pop    = active && bus.ret && !stk_empty;
    assign push   = active && !bus.ret && bus.call && !stk_full;

    ret_stack #(
        .PC_W    (PC_W),
        .STACK_D (STACK_D)
    ) u_ret_stack (
        .CLK   (CLK),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clear (bus.start),
        .din   (pc_inc),
        .dout  (stk_top),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            pc            <= '0;
            fetch_valid_q <= 1'b0;
            halt_q        <= 1'b0;
            ovf_q         <= 1'b0;
            unf_q         <= 1'b0;
        end else if (bus.start) begin
            state         <= RUN;
            pc            <= bus.start_addr;
            fetch_valid_q <= 1'b1;
            halt_q        <= 1'b0;
            ovf_q         <= 1'b0;
            unf_q         <= 1'b0;
        end else if (state == RUN && !bus.stall) begin
            if (bus.halt_req) begin
                state         <= HALT;
                fetch_valid_q <= 1'b0;
                halt_q        <= 1'b1;
            end else if (bus.ret) begin
                if (stk_empty) begin
                    unf_q         <= 1'b1;
                    state         <= HALT;
                    fetch_valid_q <= 1'b0;
                    halt_q        <= 1'b1;
                end else begin
                    pc <= stk_top;
                end
            end else if (bus.call) begin
                if (stk_full) begin
                    ovf_q         <= 1'b1;
                    state         <= HALT;
                    fetch_valid_q <= 1'b0;
                    halt_q        <= 1'b1;
                end else begin
                    pc <= target;
                end
            end else if (bus.branch && bus.taken) begin
                pc <= target;
            end else begin
                pc <= pc_inc;
            end
        end
    end

    assign bus.pc_out          = pc;
    assign bus.fetch_valid     = fetch_valid_q;
    assign bus.halt            = halt_q;
    assign bus.stack_overflow  = ovf_q;
    assign bus.stack_underflow = unf_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
    localparam int PC_W    = 8;
    localparam int STACK_D = 4;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_HALT  = 2;

    logic CLK   = 1'b0;
    logic reset = 1'b1;
    always #5 CLK = ~CLK;

    fetch_sequencer_if #(.PC_W(PC_W)) bus();

    fetch_sequencer #(
        .PC_W    (PC_W),
        .STACK_D (STACK_D)
    ) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: mode, PC, flags and the return stack as a queue.
    int              m_mode = M_IDLE;
    logic [PC_W-1:0] m_pc   = '0;
    logic            m_ovf  = 1'b0;
    logic            m_unf  = 1'b0;
    logic [PC_W-1:0] m_stk[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_in(input logic st, input logic [PC_W-1:0] sa, input logic stl,
                          input logic br, input logic tk, input logic ab,
                          input logic [PC_W-1:0] rj, input logic cl, input logic rt,
                          input logic hr);
        bus.start = st;  bus.start_addr = sa; bus.stall = stl;
        bus.branch = br; bus.taken = tk;      bus.abs_jump = ab;
        bus.rel_jump = rj; bus.call = cl;     bus.ret = rt;
        bus.halt_req = hr;
    endtask

    task automatic idle_in();
        set_in(0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_pc = '0; m_ovf = 0; m_unf = 0; m_stk.delete();
    endtask

    // Next model state from the current inputs, computed from the rules directly.
    task automatic model_edge();
        logic [PC_W-1:0] tgt;
        tgt = bus.abs_jump ? bus.rel_jump : PC_W'(int'(m_pc) + int'($signed(bus.rel_jump)));
        if (bus.start) begin
            m_mode = M_RUN; m_pc = bus.start_addr; m_ovf = 0; m_unf = 0; m_stk.delete();
        end else if (m_mode == M_RUN && !bus.stall) begin
            if (bus.halt_req) begin
                m_mode = M_HALT;
            end else if (bus.ret) begin
                if (m_stk.size() == 0) begin
                    m_unf = 1; m_mode = M_HALT;
                end else begin
                    m_pc = m_stk.pop_back();
                end
            end else if (bus.call) begin
                if (m_stk.size() == STACK_D) begin
                    m_ovf = 1; m_mode = M_HALT;
                end else begin
                    m_stk.push_back(PC_W'(m_pc + 1));
                    m_pc = tgt;
                end
            end else if (bus.branch && bus.taken) begin
                m_pc = tgt;
            end else begin
                m_pc = PC_W'(m_pc + 1);
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},  32'(bus.pc_out),          32'(m_pc));
        chk({tag, ".fv"},  32'(bus.fetch_valid),     32'(m_mode == M_RUN));
        chk({tag, ".hlt"}, 32'(bus.halt),            32'(m_mode == M_HALT));
        chk({tag, ".ovf"}, 32'(bus.stack_overflow),  32'(m_ovf));
        chk({tag, ".unf"}, 32'(bus.stack_underflow), 32'(m_unf));
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge CLK);
        #1;
        check_all(tag);
    endtask

    initial begin
        idle_in();
        #12;
        check_all("rst");
        chk("rst.pc_const", 32'(bus.pc_out), 32'h0);
        @(negedge CLK);
        reset = 1'b0;
        tick("idle");

        // Start and sequential fetch
        set_in(1, 8'h10, 0, 0, 0, 0, 8'h00, 0, 0, 0); tick("start");
        chk("start.pc", 32'(bus.pc_out), 32'h10);
        chk("start.fv", 32'(bus.fetch_valid), 32'h1);
        idle_in();
        tick("seq1"); chk("seq1.pc", 32'(bus.pc_out), 32'h11);
        tick("seq2"); chk("seq2.pc", 32'(bus.pc_out), 32'h12);
        tick("seq3"); chk("seq3.pc", 32'(bus.pc_out), 32'h13);

        // Relative branch taken / not taken, PC wrap
        set_in(1, 8'h20, 0, 0, 0, 0, 8'h00, 0, 0, 0); tick("s20");
        set_in(0, 8'h00, 0, 1, 1, 0, 8'hFC, 0, 0, 0); tick("br_t");
        chk("br_t.pc", 32'(bus.pc_out), 32'h1C);
        set_in(1, 8'h20, 0, 0, 0, 0, 8'h00, 0, 0, 0); tick("s20b");
        set_in(0, 8'h00, 0, 1, 0, 0, 8'hFC, 0, 0, 0); tick("br_nt");
        chk("br_nt.pc", 32'(bus.pc_out), 32'h21);
        set_in(1, 8'hFF, 0, 0, 0, 0, 8'h00, 0, 0, 0); tick("sff");
        idle_in(); tick("wrap");
        chk("wrap.pc", 32'(bus.pc_out), 32'h00);

        // Call / return
        set_in(1, 8'h05, 0, 0, 0, 0, 8'h00, 0, 0, 0); tick("s05");
        set_in(0, 8'h00, 0, 0, 0, 1, 8'h40, 1, 0, 0); tick("call");
        chk("call.pc", 32'(bus.pc_out), 32'h40);
        idle_in(); tick("c41"); tick("c42");
        set_in(0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 1, 0); tick("ret");
        chk("ret.pc", 32'(bus.pc_out), 32'h06);

        // Nested calls, LIFO returns, then overflow
        set_in(1, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0); tick("s00");
        for (int i = 0; i < 4; i++) begin
            set_in(0, 8'h00, 0, 0, 0, 1, 8'(8'h80 + 8'h10 * i), 1, 0, 0); tick("ncall");
        end
        chk("ncall.pc", 32'(bus.pc_out), 32'hB0);
        set_in(0, 8'h00, 0, 0, 0, 1, 8'h55, 1, 0, 0); tick("ovf");
        chk("ovf.flag", 32'(bus.stack_overflow), 32'h1);
        chk("ovf.halt", 32'(bus.halt), 32'h1);
        chk("ovf.pc", 32'(bus.pc_out), 32'hB0);
        set_in(1, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0); tick("ovf_clr");
        chk("ovf_clr.flag", 32'(bus.stack_overflow), 32'h0);
        chk("ovf_clr.fv", 32'(bus.fetch_valid), 32'h1);

        for (int i = 0; i < 4; i++) begin
            set_in(0, 8'h00, 0, 0, 0, 1, 8'(8'h80 + 8'h10 * i), 1, 0, 0); tick("ncall2");
        end
        set_in(0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 1, 0);
        tick("nret"); chk("nret1.pc", 32'(bus.pc_out), 32'hA1);
        tick("nret"); chk("nret2.pc", 32'(bus.pc_out), 32'h91);
        tick("nret"); chk("nret3.pc", 32'(bus.pc_out), 32'h81);
        tick("nret"); chk("nret4.pc", 32'(bus.pc_out), 32'h01);
        tick("unf");
        chk("unf.flag", 32'(bus.stack_underflow), 32'h1);
        chk("unf.halt", 32'(bus.halt), 32'h1);

        // Stall holds against branch and halt_req
        set_in(1, 8'h50, 0, 0, 0, 0, 8'h00, 0, 0, 0); tick("s50");
        set_in(0, 8'h00, 1, 1, 1, 1, 8'h99, 0, 0, 1); tick("stall");
        chk("stall.pc", 32'(bus.pc_out), 32'h50);
        chk("stall.fv", 32'(bus.fetch_valid), 32'h1);

        // Halt
        set_in(1, 8'h33, 0, 0, 0, 0, 8'h00, 0, 0, 0); tick("s33");
        set_in(0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 1); tick("halt");
        chk("halt.pc", 32'(bus.pc_out), 32'h33);
        chk("halt.fv", 32'(bus.fetch_valid), 32'h0);
        idle_in(); tick("halt_hold");

        // Asynchronous reset mid-run
        set_in(1, 8'h70, 0, 0, 0, 0, 8'h00, 0, 0, 0); tick("s70");
        idle_in(); tick("r71");
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all("arst");
        chk("arst.pc", 32'(bus.pc_out), 32'h0);
        @(negedge CLK);
        reset = 1'b0;

        // Randomized run
        for (int n = 0; n < 3000; n++) begin
            set_in(($urandom_range(0, 31) == 0), 8'($urandom), ($urandom_range(0, 4) == 0),
                   1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                   ($urandom_range(0, 40) == 0));
            tick("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Parametrised successor to the core's program counter. Generates the instruction-ROM address stream for the multi-cycle core.
- Adds start/halt run control, a stall hold, absolute and relative branches, and a hardware call/return stack with sticky error flags.
- Sits between the decoder/ALU (branch, call and halt requests) and instr_ROM (pc_out).

Parameters:
- PC_W, 8, width of program counter, jump offset and start address.
- STACK_D, 4, return-stack depth in entries (power of two, at least 2).

Ports:
- CLK  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle run/restart request.
- start_addr  in  PC_W  PC loaded on start.
- stall  in  1  hold the current PC; ignore branch, call, ret and halt_req.
- branch  in  1  current instruction is a branch.
- taken  in  1  branch condition is true (qualifies branch only).
- abs_jump  in  1  1: target = rel_jump as an absolute address; 0: target = PC + rel_jump.
- rel_jump  in  PC_W  two's-complement offset, or absolute target.
- call  in  1  push return address and jump to target.
- ret  in  1  pop return address into the PC.
- halt_req  in  1  decoder saw the halt instruction.
- pc_out  out  PC_W  current fetch address.
- fetch_valid  out  1  pc_out is a live fetch (RUN state).
- halt  out  1  core halted (HALT state).
- stack_overflow  out  1  sticky: call issued while the stack was full.
- stack_underflow  out  1  sticky: ret issued while the stack was empty.

Behaviour:
- Reset, asynchronous: state=IDLE, pc_out=0, sp=0, fetch_valid=0, halt=0, both error flags=0. Asserting reset mid-run aborts immediately; stack contents are don't-care.
- States: IDLE, RUN, HALT. Outputs are registered or pure state decodes: fetch_valid=(state==RUN), halt=(state==HALT).
- start, in any state, has highest priority after reset. It causes: pc_out<=start_addr, sp<=0, errors cleared, state<=RUN. This applies whether or not stall is asserted.
- IDLE: waits for start; pc_out holds.
- RUN, stall=1: pc_out, sp and state hold. All control inputs except start are ignored.
- RUN, stall=0, priority order:
  - halt_req: state<=HALT, pc_out holds.
  - ret: if sp==0, set stack_underflow, state<=HALT, pc holds. Otherwise pc_out<=stack[sp-1], sp<=sp-1.
  - call: if sp==STACK_D, set stack_overflow, state<=HALT, pc holds. Otherwise stack[sp]<=pc_out+1, sp<=sp+1, pc_out<=target.
  - branch && taken: pc_out<=target.
  - otherwise: pc_out<=pc_out+1.
- Target: abs_jump ? rel_jump : pc_out+rel_jump. The sum is PC_W bits, modulo 2^PC_W, with rel_jump treated as signed. pc_out+1 also wraps (all-ones -> 0).
- call and ret asserted together: ret wins; the call is ignored.
- sp is clog2(STACK_D)+1 bits wide; full means sp==STACK_D.
- HALT: pc_out holds. Only start or reset leaves this state. Error flags hold until start or reset.
- Latency: control inputs are sampled on the edge that ends the cycle in which pc_out is presented. The new pc_out is visible on the next cycle.

Decomposition:
- Package fetch_pkg:
  - state enum fetch_state_t {IDLE, RUN, HALT}.
  - Default PC_W and STACK_D constants.
- Sub-module ret_stack: a LIFO of STACK_D x PC_W.
  - Inputs: push, pop, clear, din.
  - Outputs: dout, full, empty.
  - Same CLK and asynchronous reset.
  - fetch_sequencer owns priority and error logic; ret_stack does no error checking.

Test Plan:
- Reset then start with start_addr=8'h10, no controls for 3 cycles -> pc_out 10,11,12,13; fetch_valid=1 from the cycle after start.
- At pc=8'h20, branch=1, taken=1, rel_jump=8'hFC -> pc_out=8'h1C. Same at pc=8'h20 with taken=0 -> 8'h21. At pc=8'hFF with no control -> 8'h00.
- call (abs_jump=1, rel_jump=8'h40) at pc=8'h05 -> pc=8'h40. Then ret at 8'h42 -> pc=8'h06. Nested 4 calls then 4 rets return in LIFO order.
- With STACK_D=4, 5th call -> stack_overflow=1, halt=1, pc holds. Then start (start_addr=0) -> flags cleared, pc=0, RUN.
- ret with an empty stack -> stack_underflow=1, halt=1. stall=1 together with branch/halt_req -> pc and state unchanged.
- halt_req at pc=8'h33 -> halt=1, fetch_valid=0, pc_out stays 8'h33. Reset asserted asynchronously mid-RUN -> outputs zero before the next edge.
